// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, FSM states
// and the encodings of the ALU / PC source selects.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_e;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. Outputs are decoded from the
// registered state (and MemReady in the memory states); also counts retired instructions.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int USE_MEM_READY = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstrCount,
    output logic [3:0]       State
);

    state_e state, next_state;
    logic   mem_rdy;
    logic   retire;
    logic   pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal;

    assign mem_rdy = (USE_MEM_READY != 0) ? MemReady : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            InstrCount <= '0;
        end else begin
            state <= next_state;
            if (retire)
                InstrCount <= InstrCount + 1'b1;
        end
    end

    always_comb begin
        next_state    = S_FETCH;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        IorD          = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_REG;
        ALUOp         = ALUOP_ADD;
        PCSource      = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                mem_read   = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ir_write   = mem_rdy;
                pc_write   = mem_rdy;
                next_state = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                ALUSrcB = SRCB_IMM_SH;
                case (Opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTYPEEX;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JEX;
                    default:      illegal    = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                next_state = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read   = 1'b1;
                IorD       = 1'b1;
                next_state = mem_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemtoReg  = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                IorD       = 1'b1;
                retire     = mem_rdy;
                next_state = mem_rdy ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALUOP_FUNC;
                next_state = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                RegDst    = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BEQEX: begin
                ALUSrcA       = 1'b1;
                ALUOp         = ALUOP_SUB;
                pc_write_cond = 1'b1;
                PCSource      = PCSRC_ALUOUT;
                retire        = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_JEX: begin
                pc_write = 1'b1;
                PCSource = PCSRC_JUMP;
                retire   = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Side-effecting strobes are suppressed while reset is held.
    assign PCWrite     = pc_write      & ~reset;
    assign PCWriteCond = pc_write_cond & ~reset;
    assign MemRead     = mem_read      & ~reset;
    assign MemWrite    = mem_write     & ~reset;
    assign IRWrite     = ir_write      & ~reset;
    assign RegWrite    = reg_write     & ~reset;
    assign Illegal     = illegal       & ~reset;
    assign State       = state;

endmodule
